// File: rtl/ghash_feeder_pkg.sv
// ============================================================================
// Module  : ghash_feeder_pkg
// Brief   : Shared GHASH feeder constants and state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ghash_feeder_pkg;

  localparam int GHASH_BLK_BYTES = 16;
  localparam int LEN_FIELD_W     = 64;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_AAD  = 3'd2,
    S_CT   = 3'd3,
    S_LEN  = 3'd4,
    S_WAIT = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ghash_tail_mask.sv
// ============================================================================
// Module  : ghash_tail_mask
// Brief   : Zero-pads a 128-bit block beyond its valid byte count (1..16).
//           Byte 0 sits at [127:120].
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ghash_tail_mask
  import ghash_feeder_pkg::*;
(
  input  logic [127:0] blk,
  input  logic [4:0]   nbytes,
  output logic [127:0] padded
);

  // Keep bytes below the valid count, clear the rest.
  always_comb begin
    padded = '0;
    for (int i = 0; i < GHASH_BLK_BYTES; i++) begin
      if (5'(i) < nbytes) begin
        padded[127-8*i -: 8] = blk[127-8*i -: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ghash_feeder.sv
// ============================================================================
// Module  : ghash_feeder
// Brief   : Sequences one GCM authentication pass into a streaming GHASH core:
//           init with H, AAD blocks, CT blocks, then the length block. Partial
//           tails are zero-padded; a single output register absorbs stalls.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ghash_feeder
  import ghash_feeder_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [127:0]     h_key,
  input  logic [LEN_W-1:0] aad_len,
  input  logic [LEN_W-1:0] ct_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic             g_init,
  output logic [127:0]     g_H,
  output logic             g_din_valid,
  input  logic             g_din_ready,
  output logic [127:0]     g_din_data,
  output logic             g_din_last,
  input  logic [127:0]     g_Y,
  input  logic             g_Y_valid,
  output logic             busy,
  output logic [127:0]     hash_out,
  output logic             hash_valid
);

  localparam logic [LEN_W-1:0] BLK = LEN_W'(GHASH_BLK_BYTES);

  state_t             state, state_nx;
  logic [127:0]       h_reg;
  logic [LEN_W-1:0]   aad_len_r, ct_len_r, rem;
  logic               out_valid, out_last;
  logic [127:0]       out_data;
  logic               slot_free, last_seg, take_blk, take_len;
  logic [4:0]         tail_bytes;
  logic [127:0]       masked;
  logic [127:0]       len_blk;

  // The output register can take a new block when empty or draining this cycle.
  assign slot_free  = ~out_valid | g_din_ready;
  assign last_seg   = (rem <= BLK);
  assign take_blk   = in_valid & in_ready;
  assign tail_bytes = (rem < BLK) ? rem[4:0] : 5'(GHASH_BLK_BYTES);
  assign len_blk    = {LEN_FIELD_W'({aad_len_r, 3'b000}), LEN_FIELD_W'({ct_len_r, 3'b000})};

  assign g_H         = h_reg;
  assign g_din_valid = out_valid;
  assign g_din_data  = out_data;
  assign g_din_last  = out_last;
  assign busy        = (state != S_IDLE);

  ghash_tail_mask u_tail_mask (
    .blk    (in_data),
    .nbytes (tail_bytes),
    .padded (masked)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic and handshake/strobe outputs.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    g_init   = 1'b0;
    take_len = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = S_INIT;
      S_INIT: begin
        g_init = 1'b1;
        if (aad_len_r != '0)     state_nx = S_AAD;
        else if (ct_len_r != '0) state_nx = S_CT;
        else                     state_nx = S_LEN;
      end
      S_AAD: begin
        in_ready = slot_free;
        if (in_valid && slot_free && last_seg)
          state_nx = (ct_len_r != '0) ? S_CT : S_LEN;
      end
      S_CT: begin
        in_ready = slot_free;
        if (in_valid && slot_free && last_seg) state_nx = S_LEN;
      end
      S_LEN: begin
        if (slot_free) begin
          take_len = 1'b1;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: if (g_Y_valid) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Pass parameters, byte counter, output register and result capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_reg      <= '0;
      aad_len_r  <= '0;
      ct_len_r   <= '0;
      rem        <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      hash_out   <= '0;
      hash_valid <= 1'b0;
    end else begin
      hash_valid <= 1'b0;
      if (state == S_IDLE && start) begin
        h_reg     <= h_key;
        aad_len_r <= aad_len;
        ct_len_r  <= ct_len;
      end
      if (state == S_INIT)
        rem <= (aad_len_r != '0) ? aad_len_r : ct_len_r;
      if (take_blk) begin
        out_data  <= masked;
        out_last  <= 1'b0;
        out_valid <= 1'b1;
        // On the final AAD block the counter reloads with the CT length.
        rem <= last_seg ? ct_len_r : (rem - BLK);
      end else if (take_len) begin
        out_data  <= len_blk;
        out_last  <= 1'b1;
        out_valid <= 1'b1;
      end else if (g_din_ready) begin
        out_valid <= 1'b0;
      end
      if (state == S_WAIT && g_Y_valid) begin
        hash_out   <= g_Y;
        hash_valid <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
